// File: rtl/nlprg_period_checker_if.sv
// Sample/result bundle between a checker and its driver.
// The driver owns start/en/d; the checker owns the status/result fields.
interface nlprg_period_checker_if #(
    parameter int N = 4
);
    logic         start;
    logic         en;
    logic [N-1:0] d;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   period;
    logic [1:0]   err;

    modport master (
        output start, en, d,
        input  busy, done, pass, period, err
    );

    modport slave (
        input  start, en, d,
        output busy, done, pass, period, err
    );
endinterface

// File: rtl/nlprg_period_checker.sv
// Period checker for nlprgN streams: locks on the zero state, then
// confirms a full 2^N cycle with no repeats; reports period and err.
module nlprg_period_checker #(
    parameter int N = 4
) (
    input logic ck,
    input logic rst,
    nlprg_period_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DONE
    } state_t;

    localparam int         M    = 1 << N;
    localparam logic [N:0] FULL = {1'b1, {N{1'b0}}};
    localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};

    localparam logic [1:0] E_NONE   = 2'd0;
    localparam logic [1:0] E_NOSYNC = 2'd1;
    localparam logic [1:0] E_SHORT  = 2'd2;
    localparam logic [1:0] E_REPEAT = 2'd3;

    state_t       state_q;
    logic [M-1:0] map_q;
    logic [N:0]   sync_q;
    logic [N:0]   per_q;
    logic [1:0]   err_q;
    logic         busy_q;
    logic         done_q;
    logic         pass_q;

    logic zero_d;
    logic hit_d;

    // Decode of the current sample against the zero state and the bitmap.
    always_comb begin
        zero_d = (bus.d == '0);
        hit_d  = map_q[bus.d];
    end

    // Checker FSM; status outputs are registered alongside the state.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            map_q   <= '0;
            sync_q  <= '0;
            per_q   <= '0;
            err_q   <= E_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // A sample coinciding with start is deliberately dropped.
                    if (bus.start) begin
                        state_q <= SYNC;
                        map_q   <= '0;
                        sync_q  <= '0;
                        per_q   <= '0;
                        err_q   <= E_NONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                SYNC: begin
                    if (bus.en) begin
                        sync_q <= sync_q + ONE;
                        if (zero_d) begin
                            state_q  <= RUN;
                            map_q[0] <= 1'b1;
                            per_q    <= ONE;
                        end else if (sync_q == FULL) begin
                            // 2^N+1 nonzero samples: generator never hit zero.
                            state_q <= DONE;
                            err_q   <= E_NOSYNC;
                            per_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        if (zero_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= (per_q == FULL) ? E_NONE : E_SHORT;
                            pass_q  <= (per_q == FULL);
                        end else if (hit_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= E_REPEAT;
                            pass_q  <= 1'b0;
                        end else begin
                            map_q[bus.d] <= 1'b1;
                            per_q        <= per_q + ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pass   = pass_q;
    assign bus.period = per_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_nlprg_period_checker.sv
// Scoreboard bench for nlprg_period_checker (N=4): stimulus queues the
// expected {err, period}; a monitor checks each rising done.
module tb_nlprg_period_checker;
    localparam int N = 4;

    logic ck;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [N+2:0] exp_q[$];
    logic         done_prev;

    nlprg_period_checker_if #(.N(N)) bus_if ();

    nlprg_period_checker #(.N(N)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus_if)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare each completed check against the oldest expectation.
    always @(negedge ck) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            if (bus_if.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got err=%0d period=%0d, expected none",
                             bus_if.err, bus_if.period);
                end else begin
                    logic [N+2:0] e;
                    e = exp_q.pop_front();
                    check("err", int'(bus_if.err), int'(e[N+2:N+1]));
                    check("period", int'(bus_if.period), int'(e[N:0]));
                    check("pass", int'(bus_if.pass), int'(e[N+2:N+1] == 2'd0));
                    check("busy_at_done", int'(bus_if.busy), 0);
                end
            end
            done_prev <= bus_if.done;
        end
    end

    task automatic expect_res(input int e, input int p);
        logic [N+2:0] v;
        v = {e[1:0], p[N:0]};
        exp_q.push_back(v);
    endtask

    task automatic do_start();
        bus_if.start = 1'b1;
        @(negedge ck);
        bus_if.start = 1'b0;
        check("busy_after_start", int'(bus_if.busy), 1);
        check("done_after_start", int'(bus_if.done), 0);
    endtask

    task automatic send(input int v);
        bus_if.en = 1'b1;
        bus_if.d  = v[N-1:0];
        @(negedge ck);
        bus_if.en = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic full_ok();
        expect_res(0, 16);
        do_start();
        for (int i = 0; i < 16; i++) send(i);
        send(0);
        check("done_latency_full", int'(bus_if.done), 1);
    endtask

    task automatic short_run();
        int seq[9] = '{0, 3, 5, 7, 9, 11, 13, 15, 0};
        expect_res(2, 8);
        do_start();
        foreach (seq[i]) send(seq[i]);
        check("done_latency_short", int'(bus_if.done), 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        done_prev = 1'b0;
        bus_if.start = 1'b0;
        bus_if.en = 1'b0;
        bus_if.d = '0;
        rst = 1'b1;
        gap(2);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_done", int'(bus_if.done), 0);
        check("rst_pass", int'(bus_if.pass), 0);
        check("rst_period", int'(bus_if.period), 0);
        check("rst_err", int'(bus_if.err), 0);
        rst = 1'b0;
        gap(1);

        // 1: full cycle
        full_ok();
        gap(2);
        check("done_holds", int'(bus_if.done), 1);

        // 2: short cycle
        short_run();
        gap(1);

        // 3: repeat
        expect_res(3, 4);
        do_start();
        send(0); send(1); send(2); send(3);
        check("no_done_before_repeat", int'(bus_if.done), 0);
        send(2);
        gap(1);

        // 4a: no sync after 17 nonzero samples
        expect_res(1, 0);
        do_start();
        for (int i = 0; i < 16; i++) send(5);
        check("sync_16_still_busy", int'(bus_if.busy), 1);
        send(5);
        check("nosync_done", int'(bus_if.done), 1);
        gap(1);

        // 4b: zero on sample 16 enters RUN; then repeat of 5
        expect_res(3, 2);
        do_start();
        for (int i = 0; i < 15; i++) send(5);
        send(0);
        send(5);
        check("late_sync_busy", int'(bus_if.busy), 1);
        check("late_sync_done", int'(bus_if.done), 0);
        send(5);
        gap(1);

        // 5: gaps and ignored start pulses during RUN
        expect_res(0, 16);
        do_start();
        for (int i = 0; i < 16; i++) begin
            send(i);
            if (i % 2 == 1) begin
                bus_if.start = (i == 5 || i == 11);
                gap(3);
                bus_if.start = 1'b0;
            end
        end
        send(0);
        gap(1);

        // 6: async reset mid-RUN, then clean runs
        do_start();
        for (int i = 0; i < 7; i++) send(i);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(bus_if.busy), 0);
        check("arst_period", int'(bus_if.period), 0);
        check("arst_err", int'(bus_if.err), 0);
        check("arst_done", int'(bus_if.done), 0);
        gap(1);
        rst = 1'b0;
        gap(1);
        full_ok();
        gap(1);
        short_run();
        gap(1);

        // 7: sample coinciding with start is not evaluated
        expect_res(3, 2);
        bus_if.start = 1'b1;
        bus_if.en = 1'b1;
        bus_if.d = '0;
        @(negedge ck);
        bus_if.start = 1'b0;
        bus_if.en = 1'b0;
        send(1); send(2); send(3); send(0);
        send(1); send(1);
        gap(1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge ck);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_results: got %0d outstanding, expected 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
